// File: rtl/fir_tap_accumulator_if.sv
// Sample/tap bus between the FIR tap accumulator and its delay line, coefficient ROM and sink.
// The slave modport is the accumulator's side; the master modport is the surrounding datapath's side.
interface fir_tap_accumulator_if;
    logic               i_sample_valid;
    logic signed [15:0] i_tap_sample;
    logic signed [15:0] i_coeff;
    logic [5:0]         o_current_count;
    logic               o_phase_63;
    logic               o_busy;
    logic [15:0]        o_filtered_sample;
    logic               o_sample_valid;
    logic               o_overrun;

    modport slave (
        input  i_sample_valid,
        input  i_tap_sample,
        input  i_coeff,
        output o_current_count,
        output o_phase_63,
        output o_busy,
        output o_filtered_sample,
        output o_sample_valid,
        output o_overrun
    );

    modport master (
        output i_sample_valid,
        output i_tap_sample,
        output i_coeff,
        input  o_current_count,
        input  o_phase_63,
        input  o_busy,
        input  o_filtered_sample,
        input  o_sample_valid,
        input  o_overrun
    );
endinterface

// File: rtl/fir_tap_accumulator.sv
// 64-tap serial FIR multiply-accumulate: one tap per cycle, Q1.15 in, saturated Q1.15 out.
// Optional macro FIR_ROUND_EN selects round-half-up instead of truncation on output.
module fir_tap_accumulator (
    input logic                  clk,
    input logic                  rst,
    fir_tap_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN1 = 2'd2,
        DRAIN2 = 2'd3
    } state_t;

`ifdef FIR_ROUND_EN
    localparam logic signed [39:0] ROUND_BIAS = 40'sd16384;
`else
    localparam logic signed [39:0] ROUND_BIAS = 40'sd0;
`endif
    localparam logic signed [39:0] SAT_POS = 40'sd1073709056;
    localparam logic signed [39:0] SAT_NEG = -40'sd1073741824;

    state_t             state_r;
    state_t             state_s;
    logic [5:0]         count_r;
    logic [5:0]         count_s;
    logic               busy_r;
    logic               start_s;
    logic               phase_63_s;
    logic signed [31:0] tap_ext_s;
    logic signed [31:0] coeff_ext_s;
    logic signed [31:0] prod_r;
    logic               prod_valid_r;
    logic               prod_first_r;
    logic signed [39:0] prod_ext_s;
    logic signed [39:0] acc_r;
    logic signed [39:0] rounded_s;
    logic [15:0]        filtered_r;
    logic               sample_valid_r;
    logic               overrun_r;

    // Clamp a Q10.30 accumulator value into Q1.15.
    function automatic logic [15:0] sat_q15(input logic signed [39:0] v);
        logic [15:0] res;
        if (v > SAT_POS) begin
            res = 16'h7FFF;
        end else if (v < SAT_NEG) begin
            res = 16'h8000;
        end else begin
            res = v[30:15];
        end
        return res;
    endfunction

    assign start_s     = bus.i_sample_valid && (state_r == IDLE);
    assign phase_63_s  = (state_r == RUN) && (count_r == 6'd63);
    assign tap_ext_s   = {{16{bus.i_tap_sample[15]}}, bus.i_tap_sample};
    assign coeff_ext_s = {{16{bus.i_coeff[15]}}, bus.i_coeff};
    assign prod_ext_s  = {{8{prod_r[31]}}, prod_r};
    assign rounded_s   = acc_r + ROUND_BIAS;

    // Next-state and tap index sequencing.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = RUN;
                    count_s = 6'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                // 63 + 1 wraps to 0, leaving the index ready for the next frame
                count_s = count_r + 6'd1;
                if (count_r == 6'd63) begin
                    state_s = DRAIN1;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN1: begin
                state_s = DRAIN2;
            end
            DRAIN2: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                count_s = 6'd0;
            end
        endcase
    end

    // State, tap index and busy flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= 6'd0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            busy_r  <= (state_s != IDLE);
        end
    end

    // Pipelined tap product; the first-tap marker tells the accumulator to load.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r       <= 32'sd0;
            prod_valid_r <= 1'b0;
            prod_first_r <= 1'b0;
        end else if (state_r == RUN) begin
            prod_r       <= tap_ext_s * coeff_ext_s;
            prod_valid_r <= 1'b1;
            prod_first_r <= (count_r == 6'd0);
        end else begin
            prod_r       <= prod_r;
            prod_valid_r <= 1'b0;
            prod_first_r <= 1'b0;
        end
    end

    // 40-bit accumulator gives 8 guard bits over 64 full-scale products.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= 40'sd0;
        end else if (prod_valid_r) begin
            if (prod_first_r) begin
                acc_r <= prod_ext_s;
            end else begin
                acc_r <= acc_r + prod_ext_s;
            end
        end else begin
            acc_r <= acc_r;
        end
    end

    // Result register and completion pulse; the accumulator is final during DRAIN2.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtered_r     <= 16'h0000;
            sample_valid_r <= 1'b0;
        end else if (state_r == DRAIN2) begin
            filtered_r     <= sat_q15(rounded_s);
            sample_valid_r <= 1'b1;
        end else begin
            filtered_r     <= filtered_r;
            sample_valid_r <= 1'b0;
        end
    end

    // Sticky overrun: a start request arriving while a frame is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r <= 1'b0;
        end else if (bus.i_sample_valid && busy_r) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign bus.o_current_count   = count_r;
    assign bus.o_phase_63        = phase_63_s;
    assign bus.o_busy            = busy_r;
    assign bus.o_filtered_sample = filtered_r;
    assign bus.o_sample_valid    = sample_valid_r;
    assign bus.o_overrun         = overrun_r;

endmodule
